// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver with a small byte FIFO.
//
// Ports:
//   clk_i        system clock (only clock)
//   rst_i        synchronous active-high reset
//   rs232_rx_i   asynchronous serial input, idles high
//   data_o       head-of-FIFO byte (holds the last popped byte when empty)
//   valid_o      FIFO holds at least one byte
//   ready_i      consumer accepts data_o; pops on valid_o & ready_i
//   frame_err_o  one-cycle pulse when the stop bit is sampled low
//   overrun_o    one-cycle pulse when a byte completes while the FIFO is full
//   busy_o       receiver FSM is not idle
module uart_rx_fifo #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SAMPLE_RATE = 16,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rs232_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SW = $clog2(SAMPLE_RATE);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] HALF_M1  = SW'(SAMPLE_RATE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(SAMPLE_RATE - 1);
  localparam logic [CW-1:0] DEPTH_CW = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Synchroniser, tick divider, receiver state
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          push_req;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q, last_d;
  logic          full, pop, push;

  assign sync1_d = rs232_rx_i;
  assign rx_s_d  = sync1_q;
  assign tick    = (div_q == DIV_MAX);
  assign div_d   = tick ? '0 : div_q + DW'(1);

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            scnt_d  = '0;
          end
        end
        ST_START: begin
          if (scnt_q == HALF_M1) begin
            scnt_d = '0;
            bidx_d = '0;
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_DATA: begin
          if (scnt_q == FULL_M1) begin
            scnt_d  = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            if (bidx_q == 3'd7) state_d = ST_STOP;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_STOP: begin
          if (scnt_q == FULL_M1) begin
            scnt_d = '0;
            if (rx_s_q) begin
              push_req = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_BREAK: begin
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is only dropped when no pop accompanies it.
  assign full      = (count_q == DEPTH_CW);
  assign pop       = valid_o & ready_i;
  assign push      = push_req & (~full | pop);
  assign overrun_d = push_req & full & ~pop;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    last_d = last_q;
    if (push) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      last_d = mem_q[rptr_q];
      rptr_d = rptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      div_q       <= '0;
      state_q     <= ST_IDLE;
      scnt_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      last_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      div_q       <= div_d;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      last_q      <= last_d;
    end
  end

  // Storage needs no reset: it is only observed while count_q is non-zero.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign valid_o     = (count_q != '0);
  assign data_o      = valid_o ? mem_q[rptr_q] : last_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
// (CLK_DIV=4, SAMPLE_RATE=16, 64 clk per bit).
module tb_uart_rx_fifo;

  localparam int unsigned BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  int checks = 0;
  int fails  = 0;

  logic [7:0] pops[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_lo = 0;

  uart_rx_fifo #(.CLK_DIV(4), .SAMPLE_RATE(16), .FIFO_DEPTH(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rs232_rx_i (rx),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Observe pops and pulses half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) pops.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  // Returns 2 time units after the n-th rising edge; inputs change only here.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    pops.delete();
    fe_cnt  = 0;
    ov_cnt  = 0;
    busy_lo = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [7:0] v;
    v = b;
    rx = 1'b0;
    cyc(BIT_CYC / 2);
    if (!busy) busy_lo++;
    cyc(BIT_CYC / 2);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      cyc(BIT_CYC / 2);
      if (!busy) busy_lo++;
      cyc(BIT_CYC / 2);
    end
    rx = stop;
    cyc(BIT_CYC);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(10);
    rst = 1'b0;
    cyc(1);
    checks++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    ready = 1'b1;
    clear_obs();
    send_frame(8'hA5, 1'b1);
    cyc(20);
    checks++; if (pops.size() !== 1) begin fails++; $display("FAIL single_count got=%0d exp=1", pops.size()); end
    checks++; if (pops.size() > 0 && pops[0] !== 8'hA5) begin fails++; $display("FAIL single_data got=%h exp=a5", pops[0]); end
    checks++; if (fe_cnt !== 0) begin fails++; $display("FAIL single_ferr got=%0d exp=0", fe_cnt); end
    checks++; if (ov_cnt !== 0) begin fails++; $display("FAIL single_ovr got=%0d exp=0", ov_cnt); end
    checks++; if (busy_lo !== 0) begin fails++; $display("FAIL single_busy_low got=%0d exp=0", busy_lo); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL single_valid_after got=%b exp=0", valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    ready = 1'b1;
    clear_obs();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    cyc(100);
    checks++; if (pops.size() !== 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", pops.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pops.size() > i && pops[i] !== exp[i]) begin
        fails++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, pops[i], exp[i]);
      end
    end
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    clear_obs();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    cyc(100);
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got=%b exp=1", valid); end
    checks++; if (ov_cnt !== 1) begin fails++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt); end
    checks++; if (data !== 8'h11) begin fails++; $display("FAIL ovr_head got=%h exp=11", data); end
    ready = 1'b1;
    cyc(20);
    checks++; if (pops.size() !== 2) begin fails++; $display("FAIL ovr_pop_count got=%0d exp=2", pops.size()); end
    checks++; if (pops.size() > 0 && pops[0] !== 8'h11) begin fails++; $display("FAIL ovr_pop0 got=%h exp=11", pops[0]); end
    checks++; if (pops.size() > 1 && pops[1] !== 8'h22) begin fails++; $display("FAIL ovr_pop1 got=%h exp=22", pops[1]); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ovr_empty got=%b exp=0", valid); end
    checks++; if (data !== 8'h22) begin fails++; $display("FAIL ovr_hold_data got=%h exp=22", data); end
  endtask

  task automatic test_frame_error();
    ready = 1'b1;
    clear_obs();
    send_frame(8'h55, 1'b0);
    cyc(30 * BIT_CYC);
    rx = 1'b1;
    cyc(200);
    checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt); end
    checks++; if (pops.size() !== 0) begin fails++; $display("FAIL ferr_no_push got=%0d exp=0", pops.size()); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_idle got=%b exp=0", busy); end
    clear_obs();
    send_frame(8'h81, 1'b1);
    cyc(20);
    checks++; if (pops.size() !== 1) begin fails++; $display("FAIL ferr_next_count got=%0d exp=1", pops.size()); end
    checks++; if (pops.size() > 0 && pops[0] !== 8'h81) begin fails++; $display("FAIL ferr_next_data got=%h exp=81", pops[0]); end
  endtask

  task automatic test_glitch();
    ready = 1'b1;
    clear_obs();
    rx = 1'b0;
    cyc(16);
    rx = 1'b1;
    cyc(200);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    checks++; if (pops.size() !== 0) begin fails++; $display("FAIL glitch_no_push got=%0d exp=0", pops.size()); end
    checks++; if (fe_cnt !== 0) begin fails++; $display("FAIL glitch_no_err got=%0d exp=0", fe_cnt); end
    send_frame(8'h7E, 1'b1);
    cyc(20);
    checks++; if (pops.size() !== 1) begin fails++; $display("FAIL glitch_next_count got=%0d exp=1", pops.size()); end
    checks++; if (pops.size() > 0 && pops[0] !== 8'h7E) begin fails++; $display("FAIL glitch_next_data got=%h exp=7e", pops[0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    v = 8'hC3;
    ready = 1'b1;
    clear_obs();
    rx = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      cyc(BIT_CYC);
    end
    rx = v[4];
    cyc(BIT_CYC / 2);
    // Transmitter abandons the frame at the same moment the receiver resets.
    rst = 1'b1;
    rx = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++; if (data !== 8'h00) begin fails++; $display("FAIL midrst_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL midrst_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL midrst_ovr got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    cyc(12 * BIT_CYC);
    checks++; if (pops.size() !== 0) begin fails++; $display("FAIL midrst_no_push got=%0d exp=0", pops.size()); end
    send_frame(8'h5A, 1'b1);
    cyc(20);
    checks++; if (pops.size() !== 1) begin fails++; $display("FAIL midrst_next_count got=%0d exp=1", pops.size()); end
    checks++; if (pops.size() > 0 && pops[0] !== 8'h5A) begin fails++; $display("FAIL midrst_next_data got=%h exp=5a", pops[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
